// File: rtl/pc_src_ctrl_if.sv
// pc_src_ctrl_if: request/flag inputs and PC-source control outputs of the
// PC-source sequencer, bundled for the control unit (master) and the
// sequencer itself (slave).
interface pc_src_ctrl_if;
  logic       fetch;
  logic       valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       div0;
  logic [2:0] PcSrc;
  logic       PcWrite;
  logic       EPCWrite;
  logic [1:0] ExcSel;
  logic       MemRdVec;
  logic       busy;
  logic       done;

  modport master (
    output fetch, valid, opcode, funct, zero, overflow, div0,
    input  PcSrc, PcWrite, EPCWrite, ExcSel, MemRdVec, busy, done
  );

  modport slave (
    input  fetch, valid, opcode, funct, zero, overflow, div0,
    output PcSrc, PcWrite, EPCWrite, ExcSel, MemRdVec, busy, done
  );
endinterface

// File: rtl/pc_src_ctrl.sv
// pc_src_ctrl: Moore sequencer driving the PcSrc mux select and PC/EPC write
// enables of the multicycle datapath.
// Optional exception handling is built when the macro PC_SRC_EXC_EN is
// defined; otherwise EPCWrite/MemRdVec/ExcSel are tied low and excepting
// instructions resolve like any non-control-flow instruction.
// Every output is a register loaded with the decode of the state being
// entered, so the outputs seen in a cycle belong to the current state.
module pc_src_ctrl #(
  parameter int VEC_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  pc_src_ctrl_if.slave bus
);

  // Catch an unsupported vector-load latency at elaboration.
  if (VEC_LAT < 1 || VEC_LAT > 3) begin : g_bad_vec_lat
    $error("pc_src_ctrl: VEC_LAT must be in 1..3");
  end

`ifdef PC_SRC_EXC_EN
  typedef enum logic [2:0] {
    IDLE, INC, RESOLVE, EXC_EPC, EXC_RD, EXC_WAIT, EXC_LD
  } state_t;

  // Cycles spent in EXC_WAIT are VEC_LAT-1; the counter counts down to 0.
  localparam logic [1:0] WAIT_LOAD = (VEC_LAT > 1) ? 2'(VEC_LAT - 2) : 2'd0;
`else
  typedef enum logic [1:0] {
    IDLE, INC, RESOLVE
  } state_t;
`endif

  state_t     state_reg, state_next;

  logic [2:0] pc_src_reg, pc_src_next;
  logic       pc_write_reg, pc_write_next;
  logic       done_reg, done_next;
  logic       busy_reg, busy_next;

  // Control-flow decision for the instruction presented with valid.
  logic [2:0] branch_src;
  logic       branch_take;

`ifdef PC_SRC_EXC_EN
  logic       epc_write_reg, epc_write_next;
  logic       mem_rd_reg, mem_rd_next;
  logic [1:0] exc_sel_reg, exc_sel_next;
  logic [1:0] exc_code_reg, exc_code_next;
  logic [1:0] wait_cnt_reg, wait_cnt_next;
  logic       op_illegal;
  logic       exc_hit;
  logic [1:0] exc_code;

  // Opcodes this datapath implements; anything else traps.
  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
      6'h0C, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B: is_legal = 1'b1;
      default:                                   is_legal = 1'b0;
    endcase
  endfunction

  // Exception classification: illegal opcode beats div0 beats overflow.
  always_comb begin
    op_illegal = !is_legal(bus.opcode);
    exc_hit    = op_illegal || bus.div0 || bus.overflow;
    if (op_illegal)
      exc_code = 2'd0;
    else if (bus.div0)
      exc_code = 2'd2;
    else
      exc_code = 2'd1;
  end
`endif

  // Branch / jump resolution from the instruction fields and ALU zero flag.
  always_comb begin
    branch_src  = 3'd0;
    branch_take = 1'b0;
    case (bus.opcode)
      6'h04: if (bus.zero) begin
        branch_src  = 3'd1;
        branch_take = 1'b1;
      end
      6'h05: if (!bus.zero) begin
        branch_src  = 3'd1;
        branch_take = 1'b1;
      end
      6'h02, 6'h03: begin
        branch_src  = 3'd2;
        branch_take = 1'b1;
      end
      6'h00: if (bus.funct == 6'h08) begin
        branch_src  = 3'd3;
        branch_take = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state selection followed by the Moore decode of the entered state.
  always_comb begin
    state_next    = state_reg;
    pc_src_next   = 3'd0;
    pc_write_next = 1'b0;
    done_next     = 1'b0;
`ifdef PC_SRC_EXC_EN
    epc_write_next = 1'b0;
    mem_rd_next    = 1'b0;
    exc_sel_next   = 2'd0;
    exc_code_next  = exc_code_reg;
    wait_cnt_next  = wait_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        // fetch has priority; a simultaneous valid is dropped.
        if (bus.fetch) begin
          state_next = INC;
        end else if (bus.valid) begin
`ifdef PC_SRC_EXC_EN
          // Exceptions are detected on the accept edge so EPC is written
          // in the very next cycle instead of spending a cycle in RESOLVE.
          if (exc_hit) begin
            state_next    = EXC_EPC;
            exc_code_next = exc_code;
          end else begin
            state_next = RESOLVE;
          end
`else
          state_next = RESOLVE;
`endif
        end
      end
      INC, RESOLVE: state_next = IDLE;
`ifdef PC_SRC_EXC_EN
      EXC_EPC: state_next = EXC_RD;
      EXC_RD: begin
        if (VEC_LAT > 1) begin
          state_next    = EXC_WAIT;
          wait_cnt_next = WAIT_LOAD;
        end else begin
          state_next = EXC_LD;
        end
      end
      EXC_WAIT: begin
        if (wait_cnt_reg == 2'd0)
          state_next = EXC_LD;
        else
          wait_cnt_next = wait_cnt_reg - 2'd1;
      end
      EXC_LD: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase

    // RESOLVE is only entered straight from IDLE, so the live instruction
    // fields here are the ones being captured on this edge.
    case (state_next)
      INC: begin
        pc_write_next = 1'b1;
        done_next     = 1'b1;
      end
      RESOLVE: begin
        pc_src_next   = branch_take ? branch_src : 3'd0;
        pc_write_next = branch_take;
        done_next     = 1'b1;
      end
`ifdef PC_SRC_EXC_EN
      EXC_EPC: begin
        epc_write_next = 1'b1;
        exc_sel_next   = exc_code_next;
      end
      EXC_RD: begin
        mem_rd_next  = 1'b1;
        exc_sel_next = exc_code_next;
      end
      EXC_WAIT: begin
        exc_sel_next = exc_code_next;
      end
      EXC_LD: begin
        pc_src_next   = 3'd4;
        pc_write_next = 1'b1;
        done_next     = 1'b1;
        exc_sel_next  = exc_code_next;
      end
`endif
      default: ;
    endcase
  end

  always_comb busy_next = (state_next != IDLE);

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      pc_src_reg   <= 3'd0;
      pc_write_reg <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_src_reg   <= pc_src_next;
      pc_write_reg <= pc_write_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

`ifdef PC_SRC_EXC_EN
  // Exception-path registers: cause code, wait counter and its outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_write_reg <= 1'b0;
      mem_rd_reg    <= 1'b0;
      exc_sel_reg   <= 2'd0;
      exc_code_reg  <= 2'd0;
      wait_cnt_reg  <= 2'd0;
    end else begin
      epc_write_reg <= epc_write_next;
      mem_rd_reg    <= mem_rd_next;
      exc_sel_reg   <= exc_sel_next;
      exc_code_reg  <= exc_code_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  assign bus.EPCWrite = epc_write_reg;
  assign bus.MemRdVec = mem_rd_reg;
  assign bus.ExcSel   = exc_sel_reg;
`else
  assign bus.EPCWrite = 1'b0;
  assign bus.MemRdVec = 1'b0;
  assign bus.ExcSel   = 2'd0;
`endif

  assign bus.PcSrc   = pc_src_reg;
  assign bus.PcWrite = pc_write_reg;
  assign bus.done    = done_reg;
  assign bus.busy    = busy_reg;

endmodule

// File: tb/tb_pc_src_ctrl.sv
// tb_pc_src_ctrl: directed table, hand-written corner sequences and random
// requests checked against a per-request expected output trace.
`timescale 1ns/1ps
module tb_pc_src_ctrl;
  localparam int VEC_LAT = 2;
`ifdef PC_SRC_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_src_ctrl_if bus ();
  pc_src_ctrl #(.VEC_LAT(VEC_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [2:0] pc_src;
    logic       pc_write;
    logic       epc_write;
    logic [1:0] exc_sel;
    logic       mem_rd;
    logic       busy;
    logic       done;
  } outs_t;

  typedef struct {
    string      name;
    logic       f, v;
    logic [5:0] op, fn;
    logic       z, o, d;
    logic [2:0] src;
    logic       pw;
  } vec_t;

  int    vectors = 0;
  int    miscompares = 0;
  outs_t exp_q[$];
  bit    epc_seen = 1'b0;

  always @(posedge clk) if (bus.EPCWrite === 1'b1) epc_seen = 1'b1;

  function automatic outs_t sample();
    outs_t s;
    s.pc_src    = bus.PcSrc;
    s.pc_write  = bus.PcWrite;
    s.epc_write = bus.EPCWrite;
    s.exc_sel   = bus.ExcSel;
    s.mem_rd    = bus.MemRdVec;
    s.busy      = bus.busy;
    s.done      = bus.done;
    return s;
  endfunction

  function automatic string fmt(input outs_t s);
    return $sformatf("src=%0d pw=%0b epc=%0b sel=%0d rd=%0b busy=%0b done=%0b",
                     s.pc_src, s.pc_write, s.epc_write, s.exc_sel, s.mem_rd, s.busy, s.done);
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = sample();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, v, input logic [5:0] op, fn, input logic z, o, d);
    bus.fetch = f; bus.valid = v; bus.opcode = op; bus.funct = fn;
    bus.zero = z; bus.overflow = o; bus.div0 = d;
  endtask

  // Reference: the cycle-by-cycle outputs a request produces, starting the
  // cycle after it is accepted and ending with the done cycle.
  function automatic void model(input logic f, v, input logic [5:0] op, fn,
                                input logic z, o, d);
    outs_t r;
    logic  illegal;
    exp_q.delete();
    r = '0;
    r.busy = 1'b1;
    illegal = !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                           6'h0C, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B});
    if (f) begin
      r.pc_write = 1'b1; r.done = 1'b1;
      exp_q.push_back(r);
    end else if (v) begin
      if (EXC_EN && (illegal || d || o)) begin
        r.exc_sel = illegal ? 2'd0 : (d ? 2'd2 : 2'd1);
        r.epc_write = 1'b1; exp_q.push_back(r); r.epc_write = 1'b0;
        r.mem_rd = 1'b1;    exp_q.push_back(r); r.mem_rd = 1'b0;
        for (int k = 1; k < VEC_LAT; k++) exp_q.push_back(r);
        r.pc_src = 3'd4; r.pc_write = 1'b1; r.done = 1'b1;
        exp_q.push_back(r);
      end else begin
        if ((op == 6'h04 && z) || (op == 6'h05 && !z)) r.pc_src = 3'd1;
        else if (op == 6'h02 || op == 6'h03)            r.pc_src = 3'd2;
        else if (op == 6'h00 && fn == 6'h08)            r.pc_src = 3'd3;
        r.pc_write = (r.pc_src != 3'd0);
        r.done = 1'b1;
        exp_q.push_back(r);
      end
    end
  endfunction

  // Issue one request from an idle cycle and follow its trace; with junk set,
  // spurious fetch/valid pulses are thrown in while the block is busy.
  task automatic run_req(input string name, input logic f, v, input logic [5:0] op, fn,
                         input logic z, o, d, input bit junk);
    check({name, " idle"}, '0);
    model(f, v, op, fn, z, o, d);
    drive(f, v, op, fn, z, o, d);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    foreach (exp_q[i]) begin
      check($sformatf("%s c%0d", name, i + 1), exp_q[i]);
      if (junk)
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 5)),
              6'h08, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    $display("txn %-12s f=%0b v=%0b op=%02h fn=%02h z=%0b o=%0b d=%0b cycles=%0d",
             name, f, v, op, fn, z, o, d, exp_q.size());
  endtask

  initial begin
    vec_t       tbl[12];
    outs_t      e;
    logic [5:0] op_pool[10];
    logic [5:0] op, fn;
    logic       f, v;
    int         kind;

    tbl[0]  = '{"fetch",     1, 0, 6'h00, 6'h00, 0, 0, 0, 3'd0, 1};
    tbl[1]  = '{"beq_taken", 0, 1, 6'h04, 6'h00, 1, 0, 0, 3'd1, 1};
    tbl[2]  = '{"beq_not",   0, 1, 6'h04, 6'h00, 0, 0, 0, 3'd0, 0};
    tbl[3]  = '{"bne_taken", 0, 1, 6'h05, 6'h00, 0, 0, 0, 3'd1, 1};
    tbl[4]  = '{"bne_not",   0, 1, 6'h05, 6'h00, 1, 0, 0, 3'd0, 0};
    tbl[5]  = '{"j",         0, 1, 6'h02, 6'h00, 0, 0, 0, 3'd2, 1};
    tbl[6]  = '{"jal",       0, 1, 6'h03, 6'h15, 1, 0, 0, 3'd2, 1};
    tbl[7]  = '{"jr",        0, 1, 6'h00, 6'h08, 0, 0, 0, 3'd3, 1};
    tbl[8]  = '{"rtype_add", 0, 1, 6'h00, 6'h20, 1, 0, 0, 3'd0, 0};
    tbl[9]  = '{"lw",        0, 1, 6'h23, 6'h08, 0, 0, 0, 3'd0, 0};
    tbl[10] = '{"fetch_wins",1, 1, 6'h02, 6'h00, 0, 0, 0, 3'd0, 1};
`ifdef PC_SRC_EXC_EN
    tbl[11] = '{"lui",       0, 1, 6'h0F, 6'h00, 0, 0, 0, 3'd0, 0};
`else
    tbl[11] = '{"illegal_ov",0, 1, 6'h3F, 6'h00, 0, 1, 1, 3'd0, 0};
`endif

    op_pool = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F, 6'h11};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("reset", '0);
    #2 reset = 1'b1;
    tick();

    // Directed table: action cycle then the idle cycle that follows.
    foreach (tbl[i]) begin
      check({tbl[i].name, " idle"}, '0);
      drive(tbl[i].f, tbl[i].v, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].o, tbl[i].d);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.pc_src = tbl[i].src; e.pc_write = tbl[i].pw;
      check(tbl[i].name, e);
      tick();
      $display("txn %-12s src=%0d pw=%0b", tbl[i].name, tbl[i].src, tbl[i].pw);
    end
    check("table tail idle", '0);

    // Reset asserted in the middle of INC.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    e = '0; e.busy = 1'b1; e.done = 1'b1; e.pc_write = 1'b1;
    check("inc before rst", e);
    #2 reset = 1'b0;
    #1 check("rst mid inc", '0);
    tick();
    check("rst held", '0);
    #2 reset = 1'b1;
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("fetch after rst", e);
    tick();
    $display("txn rst_mid_inc");

    // valid while busy is not queued.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 6'h02, 6'h00, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("valid while busy", '0);
    tick();
    check("valid while busy+1", '0);
    $display("txn valid_busy");

`ifdef PC_SRC_EXC_EN
    // Illegal opcode with overflow, VEC_LAT=2: EPC N+1, read N+2, load N+4.
    drive(0, 1, 6'h3F, 6'h00, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    e = '0; e.busy = 1'b1; e.epc_write = 1'b1;
    check("exc epc", e);
    tick();
    e = '0; e.busy = 1'b1; e.mem_rd = 1'b1;
    check("exc rd", e);
    tick();
    e = '0; e.busy = 1'b1;
    check("exc wait", e);
    tick();
    e = '0; e.busy = 1'b1; e.pc_src = 3'd4; e.pc_write = 1'b1; e.done = 1'b1;
    check("exc ld", e);
    tick();
    check("exc idle", '0);
    $display("txn exc_illegal_ovf");
    run_req("exc_div0", 0, 1, 6'h23, 6'h00, 0, 1, 1, 1'b0);
    run_req("exc_ovf", 0, 1, 6'h04, 6'h00, 1, 1, 0, 1'b1);
`endif

    // Randomised requests against the reference trace.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      f  = (kind < 2) || (kind == 9);
      v  = (kind >= 2);
      op = op_pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      fn = ($urandom_range(0, 1) == 1) ? 6'h08 : 6'($urandom);
      run_req($sformatf("rnd%0d", n), f, v, op, fn, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0), 1'b1);
    end
    check("final idle", '0);

    // EPCWrite must appear only in the exception-enabled build.
    vectors++;
    if (epc_seen !== EXC_EN) begin
      miscompares++;
      $display("FAIL epc_seen: got %0b, expected %0b", epc_seen, EXC_EN);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
